seg7_scan: RTL and testbench

Time-multiplexed 7-segment display driver that reads the BCD digit values produced by the seconds counter and other digit counters, and drives a common-anode multi-digit display. It latches a new digit set only on frame boundaries, so a digit never changes mid-frame. It inserts a blanking gap at the start of each digit slot to suppress ghosting. It sits between the counter chain and the board's segment/anode pins.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_scan_if.sv | 30 +++
 rtl/seg7_decode.sv | 28 ++
 rtl/seg7_scan.sv | 164 ++++++++++++++++
 tb/tb_seg7_scan.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment codes
// ({g,f,e,d,c,b,a}, 0 = lit) and the per-slot FSM state encoding.
// Latency: n/a (constants only). Backpressure: n/a.
package seg7_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Per-slot state: anodes off during BLANK, one anode on during DRIVE.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_t;

endpackage : seg7_pkg

// File: rtl/seg7_scan_if.sv
// Bundle between the counter chain and the display driver.
// Latency: n/a (wires only). Backpressure: none; load is a fire-and-forget strobe.
// Signals: digits_in (4*DIGITS BCD, digit k at [4k+3:4k]), load (strobe),
//          seg (7, active-low), an (DIGITS, active-low), frame_done (pulse).
// master = counter-chain side, slave = the scan driver.
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] digits_in;
  logic                load;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output digits_in,
    output load,
    input  seg,
    input  an,
    input  frame_done
  );

  modport slave (
    input  digits_in,
    input  load,
    output seg,
    output an,
    output frame_done
  );
endinterface : seg7_scan_if

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern; codes 10..15 render blank.
// Latency: combinational. Backpressure: none.
// Ports: bcd_i (4) BCD code in; seg_o (7) {g,f,e,d,c,b,a} active-low out.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule : seg7_decode

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment driver; new digits latched only at frame boundaries.
// Latency: seg/an/frame_done registered, one cycle behind the slot counters; load->display <= 1 frame + BLANK_CYC+1.
// Backpressure: none; load always accepted (last load before a boundary wins).
// Ports: clk, res (async, active-high); bus (seg7_scan_if.slave): digits_in, load in;
//        seg, an, frame_done out.
// Optional build macro LEADING_ZERO_BLANK_EN: blank digits above the most
// significant nonzero shadow digit (digit 0 always shown).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 24000,
  parameter int BLANK_CYC = 240
) (
  input  logic          clk,
  input  logic          res,
  seg7_scan_if.slave    bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  slot_state_t         state_q, state_d;

  // Digit storage: pending holds the most recent load until the next
  // boundary; shadow is what the display actually scans.
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pflag_q, pflag_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;

  // Registered outputs
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fd_q, fd_d;

  logic                slot_wrap;
  logic                boundary;
  logic [3:0]          cur_digit;
  logic [6:0]          dec_seg;
  logic                digit_show;

  assign slot_wrap = (cnt_q == CNT_LAST);
  assign boundary  = slot_wrap && (idx_q == IDX_LAST);

  // Only the digit currently being scanned is decoded.
  assign cur_digit = shadow_q[4*idx_q +: 4];

  seg7_decode u_decode (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; once a nonzero digit is seen, it and
  // every lower digit are shown. Digit 0 is forced on so zero reads "0".
  logic [DIGITS-1:0] lz_show;
  logic              lz_seen;

  always_comb begin
    lz_show = '0;
    lz_seen = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_seen    = lz_seen | (shadow_q[4*k +: 4] != 4'd0);
      lz_show[k] = lz_seen | (k == 0);
    end
  end

  assign digit_show = lz_show[idx_q];
`else
  assign digit_show = 1'b1;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    state_d  = state_q;
    pend_d   = pend_q;
    pflag_d  = pflag_q;
    shadow_d = shadow_q;
    seg_d    = SEG_BLANK;
    an_d     = '1;
    fd_d     = boundary;

    // Slot and digit counters
    if (slot_wrap) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Slot FSM: blank at the head of every slot, drive for the remainder.
    case (state_q)
      ST_BLANK: begin
        if (!slot_wrap && (int'(cnt_q) + 1 >= BLANK_CYC)) begin
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (slot_wrap) begin
          state_d = ST_BLANK;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    // Outputs follow the current state; they are registered below, so an
    // only ever switches on a cycle where the previous seg was blank.
    if (state_q == ST_DRIVE) begin
      an_d[idx_q] = 1'b0;
      seg_d       = digit_show ? dec_seg : SEG_BLANK;
    end

    // Digit update: a load landing exactly on the boundary bypasses the
    // pending stage so it is not held for an extra frame.
    if (bus.load && boundary) begin
      shadow_d = bus.digits_in;
      pflag_d  = 1'b0;
    end else begin
      if (boundary && pflag_q) begin
        shadow_d = pend_q;
        pflag_d  = 1'b0;
      end
      if (bus.load) begin
        pend_d  = bus.digits_in;
        pflag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      state_q  <= ST_BLANK;
      pend_q   <= '0;
      pflag_q  <= 1'b0;
      shadow_q <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      pend_q   <= pend_d;
      pflag_q  <= pflag_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule : seg7_scan

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with DIGITS=4, SCAN_DIV=4, BLANK_CYC=1.
// Stimulus pushes the expected {an,seg} of every drive window into a queue;
// a monitor pops one entry at the start of each drive window and compares.
module tb_seg7_scan;
  import seg7_pkg::*;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  logic clk = 1'b0;
  logic res;

  seg7_scan_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc;

  // Cycle index since reset release, aligned with the DUT slot counter.
  always @(posedge clk or posedge res) begin
    if (res) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cyc=%0d: got %0h expected %0h", name, cyc, act, req);
    end
  endfunction

  // Expected per-frame contents, digits 0..3.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    exp_q.push_back('{an: 4'hE, seg: s0});
    exp_q.push_back('{an: 4'hD, seg: s1});
    exp_q.push_back('{an: 4'hB, seg: s2});
    exp_q.push_back('{an: 4'h7, seg: s3});
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      bad++;
      total++;
      $display("FAIL wait_cyc: got cyc=%0d expected %0d", cyc, n);
    end
  endtask

  task automatic do_load(input int n, input logic [15:0] val);
    wait_cyc(n);
    bus.digits_in = val;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
    bus.digits_in = 16'h8888;  // must never reach the display
  endtask

  // Monitor
  logic [3:0] prev_an = 4'hF;
  exp_t       cur;
  logic       cur_vld = 1'b0;

  always @(negedge clk) begin
    if (res) begin
      prev_an = 4'hF;
      cur_vld = 1'b0;
    end else begin
      check("frame_done", 32'(bus.frame_done), 32'((cyc > 0) && (cyc % FRAME == 0)));
      if (bus.an != 4'hF) begin
        if (prev_an == 4'hF) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            cur_vld = 1'b0;
            $display("FAIL sb_underflow at cyc=%0d: got an=%0h seg=%0h expected no drive",
                     cyc, bus.an, bus.seg);
          end else begin
            cur     = exp_q.pop_front();
            cur_vld = 1'b1;
            check("slot_an", 32'(bus.an), 32'(cur.an));
            check("slot_seg", 32'(bus.seg), 32'(cur.seg));
          end
        end else if (cur_vld) begin
          check("hold_an", 32'(bus.an), 32'(cur.an));
          check("hold_seg", 32'(bus.seg), 32'(cur.seg));
        end
      end else begin
        check("blank_seg", 32'(bus.seg), 32'(SEG_BLANK));
      end
      prev_an = bus.an;
    end
  end

  // Stimulus
  initial begin
    res           = 1'b1;
    bus.digits_in = '0;
    bus.load      = 1'b0;
    #1;
    check("rst_seg", 32'(bus.seg), 32'(SEG_BLANK));
    check("rst_an", 32'(bus.an), 32'hF);
    check("rst_fd", 32'(bus.frame_done), 32'd0);

    // Frame 0: shadow reset to zero
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F);
`else
    push_frame(7'h40, 7'h40, 7'h40, 7'h40);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0;

    // Frame 1: load mid-frame; display unchanged this frame
    wait_cyc(16);
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F);
`else
    push_frame(7'h40, 7'h40, 7'h40, 7'h40);
`endif
    do_load(22, 16'h1259);

    // Frame 2: 1259 shown; two loads, only the last survives
    wait_cyc(32);
    push_frame(7'h10, 7'h12, 7'h24, 7'h79);
    do_load(35, 16'h0001);
    do_load(41, 16'h0009);

    // Frame 3: 0009 shown; load on the boundary cycle
    wait_cyc(48);
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(7'h10, 7'h7F, 7'h7F, 7'h7F);
`else
    push_frame(7'h10, 7'h40, 7'h40, 7'h40);
`endif
    do_load(63, 16'hFA03);

    // Frame 4: FA03 appears with no extra frame of delay
    wait_cyc(64);
    push_frame(7'h30, 7'h40, 7'h7F, 7'h7F);
    do_load(66, 16'h0007);

    // Frame 5: 0007, then reset in mid-slot drive of digit 1
    wait_cyc(80);
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(7'h78, 7'h7F, 7'h7F, 7'h7F);
`else
    push_frame(7'h78, 7'h40, 7'h40, 7'h40);
`endif
    wait_cyc(86);
    check("pre_reset_an", 32'(bus.an), 32'hD);
    #2;
    res = 1'b1;
    #1;
    check("async_rst_seg", 32'(bus.seg), 32'(SEG_BLANK));
    check("async_rst_an", 32'(bus.an), 32'hF);
    check("async_rst_fd", 32'(bus.frame_done), 32'd0);
    check("sb_left_at_reset", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);

    // First frame after release shows zero again
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F);
`else
    push_frame(7'h40, 7'h40, 7'h40, 7'h40);
`endif
    res = 1'b0;
    wait_cyc(17);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no completion expected finish before 20000");
    $fatal(1, "watchdog");
  end

endmodule : tb_seg7_scan
